sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer fed by the async-reset D flip-flop stage. It samples the registered serial bit stream on qualified clocks and assembles WIDTH-bit words, MSB first. Each completed word is presented through a valid/ready handshake, with sticky overrun detection. The downstream consumer is the lab datapath register file or ALU input latch.

---
 rtl/sipo_deser.sv | 141 ++++++++++++++
 tb/tb_sipo_deser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: MSB-first word assembly with a valid/ready output register.
// Define SIPO_DESER_PARITY_EN to append an even-parity bit to every word and drive par_err.
module sipo_deser #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             par_err
);

`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned NBits = WIDTH + 1;
`else
    localparam int unsigned NBits = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NBits - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               perr_q, perr_d;

    logic               done;
    logic [WIDTH-1:0]   word;
    logic               word_perr;
    logic [WIDTH-1:0]   shifted;

    assign shifted = {shreg_q[WIDTH-2:0], din};

`ifdef SIPO_DESER_PARITY_EN
    // Final bit is the parity bit: it completes the word but is never shifted in.
    assign word      = shreg_q;
    assign word_perr = (^shreg_q) ^ din;
`else
    logic unused_msb;
    assign unused_msb = shreg_q[WIDTH-1];
    assign word       = shifted;
    assign word_perr  = 1'b0;
`endif

    // Bit-assembly FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        if (clr) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (din_en) begin
            unique case (state_q)
                StIdle: begin
                    shreg_d = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = StShift;
                end
                StShift: begin
                    if (cnt_q == LastIdx) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
`ifndef SIPO_DESER_PARITY_EN
                        shreg_d = shifted;
`endif
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output register: a finishing word may replace one being consumed on the same edge.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        if (done) begin
            if (!valid_q || dout_ready) begin
                dout_d  = word;
                valid_d = 1'b1;
                perr_d  = word_perr;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
        end
        if (clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q == StShift);
    assign overrun    = ovr_q;
    assign par_err    = perr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: directed words are queued as issued and checked on each handshake.
// Define SIPO_DESER_PARITY_EN for both files to exercise the parity build.
module tb_sipo_deser;
    localparam int unsigned WIDTH = 8;
`ifdef SIPO_DESER_PARITY_EN
    localparam int BITS = WIDTH + 1;
`else
    localparam int BITS = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             din = 1'b0;
    logic             din_en = 1'b0;
    logic             clr = 1'b0;
    logic             dout_ready = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             overrun;
    logic             par_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] exp_data[$];
    logic             exp_par[$];
    int               xfer_cyc[$];

    sipo_deser #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_en     (din_en),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            xfer_cyc.push_back(cyc);
            if (exp_data.size() == 0) begin
                check("unexpected_word", {24'd0, dout}, 32'hDEAD);
            end else begin
                check("sb_dout", {24'd0, dout}, {24'd0, exp_data.pop_front()});
                check("sb_par_err", {31'd0, par_err}, {31'd0, exp_par.pop_front()});
            end
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] w, input logic pe);
        exp_data.push_back(w);
        exp_par.push_back(pe);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1; back-to-back calls keep din_en high continuously.
    task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input logic pb);
        for (int i = 0; i < BITS; i++) begin
            din    = (i < WIDTH) ? w[WIDTH-1-i] : pb;
            din_en = 1'b1;
            tick();
            if (i < BITS - 1) begin
                check("busy_mid", {31'd0, busy}, 32'd1);
                if (gap > 0) begin
                    din_en = 1'b0;
                    repeat (gap) tick();
                    check("busy_gap", {31'd0, busy}, 32'd1);
                    check("valid_gap", {31'd0, dout_valid}, 32'd0);
                end
            end
        end
        din_en = 1'b0;
        check("busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        #5;
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_par_err", {31'd0, par_err}, 32'd0);
        #7 rst = 1'b1;
        tick();

        // Basic word 1,0,1,0,0,1,1,0 -> A6
        dout_ready = 1'b1;
        push_exp(8'hA6, 1'b0);
        send_word(8'hA6, 0, ^8'hA6);
        check("w1_valid", {31'd0, dout_valid}, 32'd1);
        check("w1_dout", {24'd0, dout}, 32'hA6);
        tick();
        check("w1_valid_drop", {31'd0, dout_valid}, 32'd0);
        check("w1_dout_hold", {24'd0, dout}, 32'hA6);

        // Gapped input
        push_exp(8'hA6, 1'b0);
        send_word(8'hA6, 3, ^8'hA6);
        check("gap_valid", {31'd0, dout_valid}, 32'd1);
        tick();

        // Overrun: second word dropped while first is unconsumed
        dout_ready = 1'b0;
        push_exp(8'h3C, 1'b0);
        send_word(8'h3C, 0, ^8'h3C);
        send_word(8'hFF, 0, ^8'hFF);
        check("ovr_dout", {24'd0, dout}, 32'h3C);
        check("ovr_valid", {31'd0, dout_valid}, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        dout_ready = 1'b1;
        tick();
        check("ovr_valid_drop", {31'd0, dout_valid}, 32'd0);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovr_clr", {31'd0, overrun}, 32'd0);
        check("clr_keeps_dout", {24'd0, dout}, 32'h3C);

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) begin
            din = 1'b1;
            din_en = 1'b1;
            tick();
        end
        din_en = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #3 rst = 1'b0;
        #1;
        check("arst_dout", {24'd0, dout}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_valid", {31'd0, dout_valid}, 32'd0);
        check("arst_overrun", {31'd0, overrun}, 32'd0);
        #2 rst = 1'b1;
        tick();

        // clr mid-word, with a competing qualified bit that must be discarded
        for (int i = 0; i < 5; i++) begin
            din = 1'b0;
            din_en = 1'b1;
            tick();
        end
        din = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        din_en = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_valid", {31'd0, dout_valid}, 32'd0);
        push_exp(8'h5A, 1'b0);
        send_word(8'h5A, 0, ^8'h5A);
        check("clr_word", {24'd0, dout}, 32'h5A);
        tick();

        // Back-to-back words with completion and consume on shared edges
        xfer_cyc.delete();
        push_exp(8'h01, 1'b0);
        push_exp(8'h80, 1'b0);
        push_exp(8'h55, 1'b0);
        send_word(8'h01, 0, ^8'h01);
        send_word(8'h80, 0, ^8'h80);
        send_word(8'h55, 0, ^8'h55);
        tick();
        tick();
        check("b2b_count", xfer_cyc.size(), 32'd3);
        if (xfer_cyc.size() == 3) begin
            check("b2b_gap1", xfer_cyc[1] - xfer_cyc[0], BITS);
            check("b2b_gap2", xfer_cyc[2] - xfer_cyc[1], BITS);
        end
        check("b2b_overrun", {31'd0, overrun}, 32'd0);

`ifdef SIPO_DESER_PARITY_EN
        // Parity: 0F has even weight, 0E has odd weight; both sent with parity bit 0
        push_exp(8'h0F, 1'b0);
        send_word(8'h0F, 0, 1'b0);
        check("par_ok_flag", {31'd0, par_err}, 32'd0);
        tick();
        push_exp(8'h0E, 1'b1);
        send_word(8'h0E, 0, 1'b0);
        check("par_bad_flag", {31'd0, par_err}, 32'd1);
        check("par_bad_dout", {24'd0, dout}, 32'h0E);
        tick();
        check("par_clear", {31'd0, par_err}, 32'd0);
`endif

        // Drain with a bounded wait
        for (int i = 0; i < 20 && exp_data.size() != 0; i++) tick();
        check("sb_empty", exp_data.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
